// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (D/E, E/M, M/W) with hold/flush, T_new aging,
// writeback operand refresh and a saturating consecutive-hold counter.
module pipe_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 16,
  parameter int TNEW_W   = 2,
  parameter int DEC_TNEW = 1,
  parameter int REFRESH  = 1,
  parameter int HCNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              RegWrite_in,
  input  logic [TNEW_W-1:0] T_new_in,
  input  logic [4:0]        A1_in,
  input  logic [4:0]        A2_in,
  input  logic [4:0]        A3_in,
  input  logic [DATA_W-1:0] RD1_in,
  input  logic [DATA_W-1:0] RD2_in,
  input  logic [DATA_W-1:0] EXT_in,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              valid_out,
  output logic [DATA_W-1:0] PC_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              RegWrite_out,
  output logic [TNEW_W-1:0] T_new_out,
  output logic [4:0]        A1_out,
  output logic [4:0]        A2_out,
  output logic [4:0]        A3_out,
  output logic [DATA_W-1:0] RD1_out,
  output logic [DATA_W-1:0] RD2_out,
  output logic [DATA_W-1:0] EXT_out,
  output logic [HCNT_W-1:0] hold_cnt
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [CTRL_W-1:0] ctrl;
    logic              reg_write;
    logic [TNEW_W-1:0] t_new;
    logic [4:0]        a1;
    logic [4:0]        a2;
    logic [4:0]        a3;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] ext;
  } stage_t;

  localparam logic [HCNT_W-1:0] HCNT_MAX = '1;

  stage_t q, ld;
  logic   wb_ok;

  // $0 is hardwired zero in the GRF, so a write to it must never be captured.
  assign wb_ok = (REFRESH != 0) && wb_we && (wb_addr != 5'd0);

  // Next-state for a load; an invalid slot collapses to an all-zero bubble.
  always_comb begin
    ld = '0;
    if (valid_in) begin
      ld.valid     = 1'b1;
      ld.pc        = PC_in;
      ld.ctrl      = ctrl_in;
      ld.reg_write = RegWrite_in;
      if (DEC_TNEW != 0)
        ld.t_new = (T_new_in == '0) ? '0 : T_new_in - TNEW_W'(1);
      else
        ld.t_new = T_new_in;
      ld.a1  = A1_in;
      ld.a2  = A2_in;
      ld.a3  = RegWrite_in ? A3_in : 5'd0;
      ld.rd1 = (wb_ok && wb_addr == A1_in) ? wb_data : RD1_in;
      ld.rd2 = (wb_ok && wb_addr == A2_in) ? wb_data : RD2_in;
      ld.ext = EXT_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q        <= '0;
      hold_cnt <= '0;
    end else if (hold) begin
      if (q.valid) begin
        if (hold_cnt != HCNT_MAX) hold_cnt <= hold_cnt + HCNT_W'(1);
        if (wb_ok && wb_addr == q.a1) q.rd1 <= wb_data;
        if (wb_ok && wb_addr == q.a2) q.rd2 <= wb_data;
      end else begin
        hold_cnt <= '0;
      end
    end else begin
      q        <= ld;
      hold_cnt <= '0;
    end
  end

  assign valid_out    = q.valid;
  assign PC_out       = q.pc;
  assign ctrl_out     = q.ctrl;
  assign RegWrite_out = q.reg_write;
  assign T_new_out    = q.t_new;
  assign A1_out       = q.a1;
  assign A2_out       = q.a2;
  assign A3_out       = q.a3;
  assign RD1_out      = q.rd1;
  assign RD2_out      = q.rd2;
  assign EXT_out      = q.ext;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two configurations driven in lockstep, checked by
// table vectors, directed corner sequences and a randomized instruction model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, hold, flush, valid_in, RegWrite_in, wb_we;
  logic [31:0] PC_in, RD1_in, RD2_in, EXT_in, wb_data;
  logic [15:0] ctrl_in;
  logic [1:0]  T_new_in;
  logic [4:0]  A1_in, A2_in, A3_in, wb_addr;

  // Config A: DEC_TNEW=1, REFRESH=1, HCNT_W=4
  logic        vA, rwA;
  logic [31:0] pcA, rd1A, rd2A, extA;
  logic [15:0] ctlA;
  logic [1:0]  tnA;
  logic [4:0]  a1A, a2A, a3A;
  logic [3:0]  hcA;
  // Config B: DEC_TNEW=0, REFRESH=0, HCNT_W=2
  logic        vB, rwB;
  logic [31:0] pcB, rd1B, rd2B, extB;
  logic [15:0] ctlB;
  logic [1:0]  tnB;
  logic [4:0]  a1B, a2B, a3B;
  logic [1:0]  hcB;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .TNEW_W(2), .DEC_TNEW(1), .REFRESH(1), .HCNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .valid_in(valid_in),
    .PC_in(PC_in), .ctrl_in(ctrl_in), .RegWrite_in(RegWrite_in), .T_new_in(T_new_in),
    .A1_in(A1_in), .A2_in(A2_in), .A3_in(A3_in), .RD1_in(RD1_in), .RD2_in(RD2_in),
    .EXT_in(EXT_in), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .valid_out(vA), .PC_out(pcA), .ctrl_out(ctlA), .RegWrite_out(rwA), .T_new_out(tnA),
    .A1_out(a1A), .A2_out(a2A), .A3_out(a3A), .RD1_out(rd1A), .RD2_out(rd2A),
    .EXT_out(extA), .hold_cnt(hcA));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .TNEW_W(2), .DEC_TNEW(0), .REFRESH(0), .HCNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .valid_in(valid_in),
    .PC_in(PC_in), .ctrl_in(ctrl_in), .RegWrite_in(RegWrite_in), .T_new_in(T_new_in),
    .A1_in(A1_in), .A2_in(A2_in), .A3_in(A3_in), .RD1_in(RD1_in), .RD2_in(RD2_in),
    .EXT_in(EXT_in), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .valid_out(vB), .PC_out(pcB), .ctrl_out(ctlB), .RegWrite_out(rwB), .T_new_out(tnB),
    .A1_out(a1B), .A2_out(a2B), .A3_out(a3B), .RD1_out(rd1B), .RD2_out(rd2B),
    .EXT_out(extB), .hold_cnt(hcB));

  // Instruction-level model: the slot contents plus an unbounded hold count.
  typedef struct {
    bit          v;
    logic [31:0] pc, rd1, rd2, ext;
    logic [15:0] ctrl;
    bit          rw;
    int          tn;
    logic [4:0]  a1, a2, a3;
    int          held;
  } mdl_t;

  mdl_t mA, mB;

  function automatic mdl_t mstep(mdl_t m, bit dec, bit refr);
    mdl_t n;
    bit   wb = refr && wb_we && (wb_addr != 0);
    n = '{default: 0};
    if (reset || flush) return n;
    if (hold) begin
      if (m.v) begin
        m.held = m.held + 1;
        if (wb && wb_addr == m.a1) m.rd1 = wb_data;
        if (wb && wb_addr == m.a2) m.rd2 = wb_data;
      end
      return m;
    end
    if (!valid_in) return n;
    n.v    = 1;
    n.pc   = PC_in;
    n.ctrl = ctrl_in;
    n.rw   = RegWrite_in;
    n.tn   = dec ? ((int'(T_new_in) > 0) ? int'(T_new_in) - 1 : 0) : int'(T_new_in);
    n.a1   = A1_in;
    n.a2   = A2_in;
    n.a3   = RegWrite_in ? A3_in : 5'd0;
    n.rd1  = (wb && wb_addr == A1_in) ? wb_data : RD1_in;
    n.rd2  = (wb && wb_addr == A2_in) ? wb_data : RD2_in;
    n.ext  = EXT_in;
    return n;
  endfunction

  function automatic logic [255:0] mexp(mdl_t m, int hw);
    int lim = (1 << hw) - 1;
    int hc  = (m.held > lim) ? lim : m.held;
    return {m.v, m.pc, m.ctrl, m.rw, 2'(m.tn), m.a1, m.a2, m.a3, m.rd1, m.rd2, m.ext, 4'(hc)};
  endfunction

  function automatic logic [255:0] actA();
    return {vA, pcA, ctlA, rwA, tnA, a1A, a2A, a3A, rd1A, rd2A, extA, hcA};
  endfunction

  function automatic logic [255:0] actB();
    return {vB, pcB, ctlB, rwB, tnB, a1B, a2B, a3B, rd1B, rd2B, extB, 2'b00, hcB};
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    reset = 0; hold = 0; flush = 0; valid_in = 0; RegWrite_in = 0; wb_we = 0;
    PC_in = 0; RD1_in = 0; RD2_in = 0; EXT_in = 0; wb_data = 0; ctrl_in = 0;
    T_new_in = 0; A1_in = 0; A2_in = 0; A3_in = 0; wb_addr = 0;
  endtask

  // One clock: advance the models on the edge, compare both DUTs just after.
  task automatic tick(string nm);
    @(posedge clk);
    mA = mstep(mA, 1, 1);
    mB = mstep(mB, 0, 0);
    #1;
    chk({nm, "/cfgA"}, actA(), mexp(mA, 4));
    chk({nm, "/cfgB"}, actB(), mexp(mB, 2));
  endtask

  typedef struct {
    logic        hold, flush, vin;
    logic [31:0] pc;
    logic        rw;
    logic [4:0]  a3;
    logic [1:0]  tn;
    logic [4:0]  a1;
    logic [31:0] rd1;
    logic        we;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        e_v;
    logic [31:0] e_pc;
    logic [4:0]  e_a3;
    logic [1:0]  e_tn;
    logic [31:0] e_rd1;
    logic [3:0]  e_hc;
  } vec_t;

  vec_t vt[11];
  int   hx[5];

  initial begin
    // hold flush vin pc rw a3 tn a1 rd1 we wba wbd | v pc a3 tn rd1 hc   (config A)
    vt[0]  = '{0,0,1,32'h3000,1,5, 2,8,32'h11,0,0,0,          1,32'h3000,5, 1,32'h11,  0};
    vt[1]  = '{1,0,0,0,       0,0, 0,8,0,     0,0,0,          1,32'h3000,5, 1,32'h11,  1};
    vt[2]  = '{1,0,0,0,       0,0, 0,8,0,     1,8,32'hABCD,   1,32'h3000,5, 1,32'hABCD,2};
    vt[3]  = '{1,0,0,0,       0,0, 0,8,0,     0,0,0,          1,32'h3000,5, 1,32'hABCD,3};
    vt[4]  = '{0,0,1,32'h3004,0,7, 0,8,32'h22,0,0,0,          1,32'h3004,0, 0,32'h22,  0};
    vt[5]  = '{1,1,1,32'h3008,1,3, 3,1,32'h1, 0,0,0,          0,0,       0, 0,0,       0};
    vt[6]  = '{0,0,0,32'h3008,1,3, 3,1,32'h1, 0,0,0,          0,0,       0, 0,0,       0};
    vt[7]  = '{1,0,0,0,       0,0, 0,0,0,     1,4,32'h9,      0,0,       0, 0,0,       0};
    vt[8]  = '{0,0,1,32'h300C,1,31,3,4,32'h5, 1,4,32'h77,     1,32'h300C,31,2,32'h77,  0};
    vt[9]  = '{0,0,1,32'h3010,1,2, 1,0,32'h9, 1,0,32'hFF,     1,32'h3010,2, 0,32'h9,   0};
    vt[10] = '{1,0,0,0,       0,0, 0,0,0,     1,0,32'hFF,     1,32'h3010,2, 0,32'h9,   1};
    hx = '{1, 2, 3, 3, 3};

    idle();
    mA = '{default: 0};
    mB = '{default: 0};
    reset = 1;
    tick("reset");
    chk("reset_state", actA(), 256'd0);
    reset = 0;

    foreach (vt[i]) begin
      hold = vt[i].hold; flush = vt[i].flush; valid_in = vt[i].vin; PC_in = vt[i].pc;
      RegWrite_in = vt[i].rw; A3_in = vt[i].a3; T_new_in = vt[i].tn; A1_in = vt[i].a1;
      RD1_in = vt[i].rd1; wb_we = vt[i].we; wb_addr = vt[i].wba; wb_data = vt[i].wbd;
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_fields", i), {vA, pcA, a3A, tnA, rd1A, hcA},
          {vt[i].e_v, vt[i].e_pc, vt[i].e_a3, vt[i].e_tn, vt[i].e_rd1, vt[i].e_hc});
    end

    // Hold saturation on the narrow counter; $0 writeback never refreshes.
    idle();
    valid_in = 1; PC_in = 32'h40; RegWrite_in = 1; A3_in = 3; T_new_in = 1; RD1_in = 32'h11;
    tick("sat_load");
    idle();
    hold = 1; wb_we = 1; wb_addr = 0; wb_data = 32'hDEAD;
    for (int i = 0; i < 5; i++) begin
      tick("sat_hold");
      chk($sformatf("sat_hcnt%0d", i), {30'd0, hcB}, 32'(hx[i]));
      chk($sformatf("sat_rd1_%0d", i), rd1A, 32'h11);
    end

    // Both operands match the same writeback address on load.
    idle();
    valid_in = 1; A1_in = 9; A2_in = 9; RD1_in = 1; RD2_in = 1;
    wb_we = 1; wb_addr = 9; wb_data = 32'h55;
    tick("dual_refresh");
    chk("dual_refresh_on", {rd1A, rd2A}, {32'h55, 32'h55});
    chk("dual_refresh_off", {rd1B, rd2B}, {32'h1, 32'h1});

    // Reset landing mid-hold clears everything on that edge.
    idle();
    hold = 1;
    tick("pre_reset_hold");
    reset = 1;
    tick("reset_in_hold");
    chk("reset_in_hold_A", actA(), 256'd0);
    chk("reset_in_hold_B", actB(), 256'd0);

    // Randomized traffic with small register numbers so hazards collide often.
    idle();
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      hold        = ($urandom_range(0, 9) < 4);
      valid_in    = ($urandom_range(0, 9) < 8);
      RegWrite_in = $urandom_range(0, 1);
      PC_in       = $urandom;
      ctrl_in     = 16'($urandom);
      T_new_in    = 2'($urandom);
      A1_in       = 5'($urandom_range(0, 3));
      A2_in       = 5'($urandom_range(0, 3));
      A3_in       = 5'($urandom);
      RD1_in      = $urandom;
      RD2_in      = $urandom;
      EXT_in      = $urandom;
      wb_we       = $urandom_range(0, 1);
      wb_addr     = 5'($urandom_range(0, 3));
      wb_data     = $urandom;
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the 5-stage MIPS core. One module serves the D/E, E/M and M/W boundaries.
- Separate hold (freeze) and flush (bubble) controls.
- Carries a valid bit and auto-decrements T_new per stage.
- Refreshes held operands from the writeback port, so stalled instructions never keep stale GRF data.
- Counts consecutive hold cycles for the hazard unit.

Parameters:
DATA_W, 32, width of PC, operand and immediate fields
CTRL_W, 16, width of opaque packed control bundle (ALUOP, MemtoReg, storeOP, DextOP, ...)
TNEW_W, 2, width of T_new field
DEC_TNEW, 1, 1: stored T_new = saturating (T_new_in - 1); 0: stored as-is
REFRESH, 1, 1: enable writeback capture into RD1/RD2 on load and on hold
HCNT_W, 4, width of consecutive-hold counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; clears all state
hold  in  1  freeze contents (downstream stall)
flush  in  1  load a bubble
valid_in  in  1  incoming slot holds a real instruction
PC_in  in  DATA_W  instruction PC
ctrl_in  in  CTRL_W  packed control bundle
RegWrite_in  in  1  instruction writes GRF
T_new_in  in  TNEW_W  cycles until result is ready, relative to the previous stage
A1_in, A2_in, A3_in  in  5 each  rs/rt/destination register numbers
RD1_in, RD2_in  in  DATA_W each  operand values
EXT_in  in  DATA_W  extended immediate
wb_we  in  1  GRF write strobe from W stage
wb_addr  in  5  GRF write address
wb_data  in  DATA_W  GRF write data
valid_out, PC_out, ctrl_out, RegWrite_out, T_new_out, A1_out, A2_out, A3_out, RD1_out, RD2_out, EXT_out  out  registered counterparts of the inputs
hold_cnt  out  HCNT_W  consecutive cycles the current valid entry has been held, saturating

Behaviour:
- Priority per rising edge: reset > flush > hold > load.
- Reset or flush: every output is 0. This includes valid_out, A3_out, RegWrite_out, T_new_out and hold_cnt.
- Load (no reset, no flush, no hold):
  - All fields are captured from their inputs.
  - valid_out = valid_in.
  - If valid_in=0, the slot behaves as a bubble and all fields are 0.
- A3_out = 0 whenever RegWrite_in = 0, so forwarding never matches a non-writing instruction.
- T_new on load:
  - DEC_TNEW=1: stored value = T_new_in - 1, saturating at 0 (T_new_in=0 gives 0).
  - DEC_TNEW=0: stored value = T_new_in.
- Hold:
  - All fields retain their values; T_new_out is not decremented while held.
  - hold_cnt increments by 1 when valid_out=1, saturating at 2^HCNT_W - 1.
  - hold_cnt stays 0 when valid_out=0.
- Load and flush both clear hold_cnt to 0.
- Refresh, only when REFRESH=1 and the condition wb_we=1 and wb_addr != 0 holds:
  - On load: if wb_addr == A1_in, RD1_out takes wb_data instead of RD1_in. RD2 is handled the same way against A2_in.
  - On hold with valid_out=1: if wb_addr == A1_out, RD1_out takes wb_data. RD2 is handled the same way against A2_out.
  - Register $0 is never refreshed.
  - A1 and A2 may match the same wb_addr; both operands then update in that cycle.
- Hold and flush asserted together: flush wins and a bubble is inserted. The held instruction is discarded; the hazard unit is responsible for not doing this unintentionally.
- Reset asserted mid-hold clears everything, including hold_cnt, on that same edge.
- Latency is 1 cycle on load; there is no combinational path from input to output.
- Never produce X on outputs after the first reset edge.

Test Plan:
1. Reset, then load valid_in=1, PC_in=0x3000, RegWrite_in=1, A3_in=5, T_new_in=2, DEC_TNEW=1 → next cycle: valid_out=1, PC_out=0x3000, A3_out=5, T_new_out=1, hold_cnt=0.
2. Load RegWrite_in=0, A3_in=7, T_new_in=0 → A3_out=0, T_new_out=0 (saturated, no underflow to 3).
3. Hold for 3 cycles with valid entry A1_out=8, RD1_out=0x11; in cycle 2 drive wb_we=1, wb_addr=8, wb_data=0xABCD → RD1_out=0xABCD from the following edge, other fields unchanged, T_new_out unchanged, hold_cnt=1,2,3.
4. Same as 3 but wb_addr=0, A1_out=0 → RD1_out unchanged; HCNT_W=2 with 5 hold cycles → hold_cnt saturates at 3.
5. hold=1 and flush=1 on the same edge with a valid entry → all outputs 0, hold_cnt=0; next load with valid_in=1 proceeds normally.
6. Load with A1_in=A2_in=9, wb_we=1, wb_addr=9, wb_data=0x55, RD1_in=RD2_in=0x1 → RD1_out=RD2_out=0x55. Repeat with REFRESH=0 → both 0x1. Assert reset during a hold → all outputs 0 next edge.
